uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first: the receive-side counterpart of `uart_tx`. It deserialises the board UART line (`board1_rx` / `ftdi_rx` at `top`) into bytes. Each received byte is delivered on a parallel output with a one-cycle valid strobe. The block oversamples by clock count: it synchronises the line, qualifies the start bit at mid-bit, samples each data bit at mid-bit and checks the stop bit.

---
 rtl/uart_rx.sv | 107 ++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver, LSB first, with mid-bit sampling by clock count.
// Delivers each good byte with a one-cycle valid strobe; a low stop bit gives a frame_err strobe.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
   localparam logic [CW-1:0] FULL_END = CW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP      = 3'd3;
   localparam logic [2:0] WAIT_HIGH = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          din_m;
   logic          din_s;

   // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         din_m <= 1'b1;
         din_s <= 1'b1;
      end else begin
         din_m <= din;
         din_s <= din_m;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         data_out  <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!din_s) state <= START;
            end
            START: begin
               if (cnt == HALF_END) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= din_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == FULL_END) begin
                  cnt        <= '0;
                  shreg[idx] <= din_s;
                  if (idx == 3'd7) state <= STOP;
                  else             idx   <= idx + 3'd1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               // Leave at mid-stop so a start bit right after the stop bit is not missed.
               if (cnt == FULL_END) begin
                  cnt <= '0;
                  if (din_s) begin
                     data_out <= shreg;
                     valid    <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_HIGH: begin
               if (din_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames scored against a byte-queue model.
// The line is driven by a behavioural 8N1 transmitter task at 16 clocks per bit.
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;

   logic       clk;
   logic       rst;
   logic       din;
   logic [7:0] data_out;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int error_count = 0;
   int check_count = 0;
   int valid_count = 0;
   int ferr_count  = 0;
   int cycle       = 0;
   bit tolerate    = 1'b0;

   logic [7:0] exp_q[$];
   int         valid_times[$];

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .data_out  (data_out),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  tag, observed, observed, expected, expected, cycle);
      end
   endtask

   // Scoreboard: every good frame's byte is queued by the transmitter and must pop out in order.
   always @(negedge clk) begin
      if (valid || frame_err) checkOutput("valid_ferr_exclusive", int'(valid && frame_err), 0);
      if (valid) begin
         valid_count++;
         valid_times.push_back(cycle);
         if (!tolerate) begin
            if (exp_q.size() == 0) checkOutput("spurious_valid", 1, 0);
            else                   checkOutput("rx_byte", int'(data_out), int'(exp_q.pop_front()));
         end
      end
      if (frame_err) ferr_count++;
   end

   task automatic idleCycles(input int n);
      din = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // 8N1 frame, LSB first; queues the byte as expected only when the stop bit is good.
   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input bit push_exp);
      if (push_exp && stop_bit) exp_q.push_back(b);
      din = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         din = b[i];
         repeat (CPB) @(negedge clk);
      end
      din = stop_bit;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic waitForValid(input string tag);
      int n;
      n = 0;
      while (!valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, int'(valid), 1);
   endtask

   initial begin
      int v0, f0, bad_expected, gap;
      logic [7:0] b, last_good;
      logic bad;

      din = 1'b1;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("reset_data_out", int'(data_out), 0);
      checkOutput("reset_valid", int'(valid), 0);
      checkOutput("reset_frame_err", int'(frame_err), 0);
      checkOutput("reset_busy", int'(busy), 0);
      rst = 1'b1;
      idleCycles(20);

      // Single byte
      v0 = valid_count; f0 = ferr_count;
      fork
         applyStimulus(8'h3A, 1'b1, 1'b1);
      join_none
      waitForValid("single_valid_seen");
      checkOutput("single_data", int'(data_out), 8'h3A);
      @(negedge clk);
      checkOutput("single_valid_width", int'(valid), 0);
      checkOutput("single_busy_after", int'(busy), 0);
      wait fork;
      idleCycles(20);
      checkOutput("single_valid_count", valid_count - v0, 1);
      checkOutput("single_no_ferr", ferr_count - f0, 0);

      // Back-to-back, no idle gap
      valid_times.delete();
      applyStimulus(8'h69, 1'b1, 1'b1);
      applyStimulus(8'h00, 1'b1, 1'b1);
      applyStimulus(8'hFF, 1'b1, 1'b1);
      idleCycles(20);
      checkOutput("b2b_count", valid_times.size(), 3);
      if (valid_times.size() == 3) begin
         checkOutput("b2b_gap1_in_range",
                     int'(valid_times[1] - valid_times[0] >= 159 && valid_times[1] - valid_times[0] <= 161), 1);
         checkOutput("b2b_gap2_in_range",
                     int'(valid_times[2] - valid_times[1] >= 159 && valid_times[2] - valid_times[1] <= 161), 1);
      end
      checkOutput("b2b_pending", exp_q.size(), 0);

      // Glitch rejection
      v0 = valid_count; f0 = ferr_count;
      din = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("glitch_busy_rises", int'(busy), 1);
      @(negedge clk);
      din = 1'b1;
      repeat (HALF + 4 - 5) @(negedge clk);
      checkOutput("glitch_busy_drops", int'(busy), 0);
      idleCycles(400);
      checkOutput("glitch_no_valid", valid_count - v0, 0);
      checkOutput("glitch_no_ferr", ferr_count - f0, 0);
      checkOutput("glitch_data_kept", int'(data_out), 8'hFF);

      // Framing error with a held-low line
      v0 = valid_count; f0 = ferr_count;
      applyStimulus(8'hA5, 1'b0, 1'b1);
      repeat (100) @(negedge clk);
      idleCycles(40);
      checkOutput("ferr_pulses", ferr_count - f0, 1);
      checkOutput("ferr_no_valid", valid_count - v0, 0);
      checkOutput("ferr_data_kept", int'(data_out), 8'hFF);
      applyStimulus(8'h5A, 1'b1, 1'b1);
      idleCycles(20);
      checkOutput("after_ferr_data", int'(data_out), 8'h5A);
      checkOutput("after_ferr_pending", exp_q.size(), 0);

      // Reset during bit 4; any resync junk afterwards is ignored
      tolerate = 1'b1;
      fork
         applyStimulus(8'hC3, 1'b1, 1'b0);
         begin
            repeat (5 * CPB + HALF) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            checkOutput("midreset_data_out", int'(data_out), 0);
            checkOutput("midreset_valid", int'(valid), 0);
            checkOutput("midreset_frame_err", int'(frame_err), 0);
            checkOutput("midreset_busy", int'(busy), 0);
            rst = 1'b1;
         end
      join
      idleCycles(200);
      tolerate = 1'b0;
      applyStimulus(8'h3C, 1'b1, 1'b1);
      idleCycles(20);
      checkOutput("after_reset_data", int'(data_out), 8'h3C);
      checkOutput("after_reset_pending", exp_q.size(), 0);

      // Randomized frames, some with bad stop bits and random idle gaps
      f0 = ferr_count;
      bad_expected = 0;
      last_good = 8'h3C;
      for (int k = 0; k < 24; k++) begin
         b   = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 4) == 0);
         if (bad) bad_expected++;
         else     last_good = b;
         applyStimulus(b, !bad, 1'b1);
         gap = bad ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 2));
         if (gap > 0) idleCycles(gap * CPB);
      end
      idleCycles(40);
      checkOutput("rand_pending", exp_q.size(), 0);
      checkOutput("rand_ferr_count", ferr_count - f0, bad_expected);
      checkOutput("rand_last_data", int'(data_out), int'(last_good));
      checkOutput("rand_idle_busy", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
